// File: rtl/traffic_phase_scheduler_pkg.sv
// Shared types and constants for the highway/country phase scheduler.
// Holds the state codes, the lamp patterns and the lamp decode used by the top.
package tlc_pkg;

  localparam int STATE_W = 3;

  // State codes as seen on the debug "state" bus
  localparam logic [STATE_W-1:0] HW_GREEN  = 3'd0;
  localparam logic [STATE_W-1:0] HW_YELLOW = 3'd1;
  localparam logic [STATE_W-1:0] ALL_RED_A = 3'd2;
  localparam logic [STATE_W-1:0] CR_GREEN  = 3'd3;
  localparam logic [STATE_W-1:0] CR_YELLOW = 3'd4;
  localparam logic [STATE_W-1:0] ALL_RED_B = 3'd5;

  // Lamp bus patterns, {red,yellow,green}
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  typedef enum logic [STATE_W-1:0] {
    ST_HW_GREEN  = HW_GREEN,
    ST_HW_YELLOW = HW_YELLOW,
    ST_ALL_RED_A = ALL_RED_A,
    ST_CR_GREEN  = CR_GREEN,
    ST_CR_YELLOW = CR_YELLOW,
    ST_ALL_RED_B = ALL_RED_B
  } state_t;

  typedef struct packed {
    logic [2:0] highway;
    logic [2:0] country;
    logic       walk;
  } lamps_t;

  // Larger of two integers, used to size the phase timer
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Lamp pattern shown while in a given state; anything unknown shows all red
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l.highway = LIGHT_RED;
    l.country = LIGHT_RED;
    l.walk    = 1'b0;
    case (s)
      ST_HW_GREEN: begin
        l.highway = LIGHT_GREEN;
        l.country = LIGHT_RED;
      end
      ST_HW_YELLOW: begin
        l.highway = LIGHT_YELLOW;
        l.country = LIGHT_RED;
      end
      ST_ALL_RED_A: begin
        l.highway = LIGHT_RED;
        l.country = LIGHT_RED;
      end
      ST_CR_GREEN: begin
        l.highway = LIGHT_RED;
        l.country = LIGHT_GREEN;
        l.walk    = 1'b1;
      end
      ST_CR_YELLOW: begin
        l.highway = LIGHT_RED;
        l.country = LIGHT_YELLOW;
      end
      ST_ALL_RED_B: begin
        l.highway = LIGHT_RED;
        l.country = LIGHT_RED;
      end
      default: begin
        l.highway = LIGHT_RED;
        l.country = LIGHT_RED;
        l.walk    = 1'b0;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_scheduler_phase_timer.sv
// Dwell timer for the phase scheduler: counts cycles spent in the current
// state, restarts from zero on request and sticks at all-ones instead of wrapping.
module phase_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] COUNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] COUNT_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_r;

  // Saturating up-count; clear and reset both return to zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_r <= COUNT_ZERO;
    end else if (clear) begin
      count_r <= COUNT_ZERO;
    end else if (count_r != COUNT_MAX) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-driven highway/country intersection sequencer. Highway green is the
// resting phase; the country road is served on vehicle or pedestrian demand,
// with timed yellow and all-red clearance, and highway emergency preemption.
// Lamp outputs are registered from the next-state decode so they change on
// the same edge as the state register and never glitch.
module traffic_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int HW_MIN_GREEN = 8,
  parameter int CR_MIN_GREEN = 4,
  parameter int CR_MAX_GREEN = 12,
  parameter int YELLOW_TIME  = 3,
  parameter int RED_CLEAR    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               country_car,
  input  logic               ped_req,
  input  logic               emerg_hw,
  output logic [2:0]         highway_lights,
  output logic [2:0]         country_lights,
  output logic               walk,
  output logic               ped_pending,
  output logic [STATE_W-1:0] state
);

  localparam int MAX_DWELL = max_int(max_int(max_int(HW_MIN_GREEN, CR_MIN_GREEN),
                                             max_int(CR_MAX_GREEN, YELLOW_TIME)),
                                     RED_CLEAR);
  localparam int TIMER_W = $clog2(MAX_DWELL) + 1;

  // Last timer value of each dwell; exiting at this value gives exactly N cycles
  localparam logic [TIMER_W-1:0] HW_MIN_LAST = TIMER_W'(HW_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] CR_MIN_LAST = TIMER_W'(CR_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] CR_MAX_LAST = TIMER_W'(CR_MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LAST = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] RED_LAST    = TIMER_W'(RED_CLEAR - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic               state_change_s;
  logic [TIMER_W-1:0] timer_s;
  logic               ped_pending_r;
  logic               ped_next_s;
  lamps_t             lamps_next_s;
  lamps_t             reset_lamps_s;
  logic [2:0]         highway_lights_r;
  logic [2:0]         country_lights_r;
  logic               walk_r;

  phase_timer #(
    .WIDTH (TIMER_W)
  ) u_phase_timer (
    .clk   (clk),
    .reset (reset),
    .clear (state_change_s),
    .count (timer_s)
  );

  // Next-state logic; comparisons use >= so a saturated timer still exits
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_HW_GREEN: begin
        // Emergency on the highway suppresses all cross demand
        if ((timer_s >= HW_MIN_LAST) && (country_car || ped_pending_r) && !emerg_hw) begin
          state_next_s = ST_HW_YELLOW;
        end else begin
          state_next_s = ST_HW_GREEN;
        end
      end
      ST_HW_YELLOW: begin
        if (timer_s >= YELLOW_LAST) begin
          state_next_s = ST_ALL_RED_A;
        end else begin
          state_next_s = ST_HW_YELLOW;
        end
      end
      ST_ALL_RED_A: begin
        // Preemption arriving during clearance returns straight to highway green
        if (timer_s >= RED_LAST) begin
          if (emerg_hw) begin
            state_next_s = ST_HW_GREEN;
          end else begin
            state_next_s = ST_CR_GREEN;
          end
        end else begin
          state_next_s = ST_ALL_RED_A;
        end
      end
      ST_CR_GREEN: begin
        if (emerg_hw ||
            ((timer_s >= CR_MIN_LAST) && !country_car) ||
            (timer_s >= CR_MAX_LAST)) begin
          state_next_s = ST_CR_YELLOW;
        end else begin
          state_next_s = ST_CR_GREEN;
        end
      end
      ST_CR_YELLOW: begin
        if (timer_s >= YELLOW_LAST) begin
          state_next_s = ST_ALL_RED_B;
        end else begin
          state_next_s = ST_CR_YELLOW;
        end
      end
      ST_ALL_RED_B: begin
        if (timer_s >= RED_LAST) begin
          state_next_s = ST_HW_GREEN;
        end else begin
          state_next_s = ST_ALL_RED_B;
        end
      end
      default: begin
        state_next_s = ST_HW_GREEN;
      end
    endcase
  end

  // Timer restart, pedestrian latch update and next lamp pattern
  always_comb begin
    state_change_s = (state_next_s != state_r);
    lamps_next_s   = decode_lamps(state_next_s);
    reset_lamps_s  = decode_lamps(ST_HW_GREEN);
    // A new request on the serving edge wins so it is not silently lost
    if (ped_req) begin
      ped_next_s = 1'b1;
    end else if ((state_next_s == ST_CR_GREEN) && (state_r != ST_CR_GREEN)) begin
      ped_next_s = 1'b0;
    end else begin
      ped_next_s = ped_pending_r;
    end
  end

  // FSM state, pedestrian latch and registered lamp outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r          <= ST_HW_GREEN;
      ped_pending_r    <= 1'b0;
      highway_lights_r <= reset_lamps_s.highway;
      country_lights_r <= reset_lamps_s.country;
      walk_r           <= reset_lamps_s.walk;
    end else begin
      state_r          <= state_next_s;
      ped_pending_r    <= ped_next_s;
      highway_lights_r <= lamps_next_s.highway;
      country_lights_r <= lamps_next_s.country;
      walk_r           <= lamps_next_s.walk;
    end
  end

  assign highway_lights = highway_lights_r;
  assign country_lights = country_lights_r;
  assign walk           = walk_r;
  assign ped_pending    = ped_pending_r;
  assign state          = state_r;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: the driver pushes the
// hand-computed expected state/ped_pending for every edge it issues, and a
// negedge monitor pops and compares against the DUT outputs.
module tb_traffic_phase_scheduler;

  localparam logic [2:0] HWG = 3'd0;
  localparam logic [2:0] HWY = 3'd1;
  localparam logic [2:0] ARA = 3'd2;
  localparam logic [2:0] CRG = 3'd3;
  localparam logic [2:0] CRY = 3'd4;
  localparam logic [2:0] ARB = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       country_car = 1'b0;
  logic       ped_req = 1'b0;
  logic       emerg_hw = 1'b0;
  logic [2:0] highway_lights;
  logic [2:0] country_lights;
  logic       walk;
  logic       ped_pending;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       pend;
  } exp_t;

  exp_t  exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  string test_name = "none";

  traffic_phase_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .country_car    (country_car),
    .ped_req        (ped_req),
    .emerg_hw       (emerg_hw),
    .highway_lights (highway_lights),
    .country_lights (country_lights),
    .walk           (walk),
    .ped_pending    (ped_pending),
    .state          (state)
  );

  always #5 clk = ~clk;

  // Reference lamp table: {highway, country, walk}
  function automatic logic [6:0] lamp_ref(input logic [2:0] s);
    case (s)
      3'd0:    return {3'b001, 3'b100, 1'b0};
      3'd1:    return {3'b010, 3'b100, 1'b0};
      3'd2:    return {3'b100, 3'b100, 1'b0};
      3'd3:    return {3'b100, 3'b001, 1'b1};
      3'd4:    return {3'b100, 3'b010, 1'b0};
      3'd5:    return {3'b100, 3'b100, 1'b0};
      default: return {3'b100, 3'b100, 1'b0};
    endcase
  endfunction

  // Monitor: safety invariant every cycle, scoreboard compare per pushed edge
  always @(negedge clk) begin
    exp_t        e;
    logic [10:0] got;
    logic [10:0] want;
    if ((highway_lights != 3'b100) && (country_lights != 3'b100)) begin
      miscompares++;
      $display("FAIL invariant [%s] both roads non-red: highway=%b country=%b", test_name,
               highway_lights, country_lights);
    end
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      got  = {state, highway_lights, country_lights, walk, ped_pending};
      want = {e.st, lamp_ref(e.st), e.pend};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s vec%0d: got state=%0d hw=%b cr=%b walk=%b pend=%b, expected state=%0d hw=%b cr=%b walk=%b pend=%b",
                 test_name, vectors, got[10:8], got[7:5], got[4:2], got[1], got[0],
                 want[10:8], want[7:5], want[4:2], want[1], want[0]);
      end
    end
  end

  // One clock edge with the given inputs; expected outputs after that edge are queued
  task automatic cyc(input logic rst_v, input logic car, input logic ped, input logic em,
                     input logic [2:0] st, input logic pend);
    exp_t e;
    #1;
    reset       = rst_v;
    country_car = car;
    ped_req     = ped;
    emerg_hw    = em;
    @(posedge clk);
    e.st   = st;
    e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic car, input logic ped, input logic em,
                     input logic [2:0] st, input logic pend);
    for (int i = 0; i < n; i++) cyc(1'b1, car, ped, em, st, pend);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, HWG, 1'b0);
  endtask

  initial begin
    // Idle: highway green holds forever
    test_name = "idle";
    do_reset();
    run(30, 1'b0, 1'b0, 1'b0, HWG, 1'b0);

    // Continuous country demand: max green cap
    test_name = "car_held";
    do_reset();
    run(7,  1'b1, 1'b0, 1'b0, HWG, 1'b0);
    run(3,  1'b1, 1'b0, 1'b0, HWY, 1'b0);
    run(2,  1'b1, 1'b0, 1'b0, ARA, 1'b0);
    run(12, 1'b1, 1'b0, 1'b0, CRG, 1'b0);
    run(3,  1'b1, 1'b0, 1'b0, CRY, 1'b0);
    run(2,  1'b1, 1'b0, 1'b0, ARB, 1'b0);
    run(4,  1'b1, 1'b0, 1'b0, HWG, 1'b0);

    // Pedestrian pulse at cycle 3, no vehicles
    test_name = "ped";
    do_reset();
    run(2, 1'b0, 1'b0, 1'b0, HWG, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, HWG, 1'b1);
    run(4, 1'b0, 1'b0, 1'b0, HWG, 1'b1);
    run(3, 1'b0, 1'b0, 1'b0, HWY, 1'b1);
    run(2, 1'b0, 1'b0, 1'b0, ARA, 1'b1);
    run(4, 1'b0, 1'b0, 1'b0, CRG, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, CRY, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, ARB, 1'b0);
    run(5, 1'b0, 1'b0, 1'b0, HWG, 1'b0);

    // Car leaves two cycles into country green: minimum green
    test_name = "car_drop";
    do_reset();
    run(7, 1'b1, 1'b0, 1'b0, HWG, 1'b0);
    run(3, 1'b1, 1'b0, 1'b0, HWY, 1'b0);
    run(2, 1'b1, 1'b0, 1'b0, ARA, 1'b0);
    run(2, 1'b1, 1'b0, 1'b0, CRG, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, CRG, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, CRY, 1'b0);
    run(2, 1'b0, 1'b0, 1'b0, ARB, 1'b0);
    run(3, 1'b0, 1'b0, 1'b0, HWG, 1'b0);

    // Emergency at CR_GREEN timer 1, then hold highway despite all demand
    test_name = "emerg_cr";
    do_reset();
    run(7, 1'b1, 1'b0, 1'b0, HWG, 1'b0);
    run(3, 1'b1, 1'b0, 1'b0, HWY, 1'b0);
    run(2, 1'b1, 1'b0, 1'b0, ARA, 1'b0);
    run(2, 1'b1, 1'b0, 1'b0, CRG, 1'b0);
    run(3, 1'b1, 1'b0, 1'b1, CRY, 1'b0);
    run(2, 1'b1, 1'b0, 1'b1, ARB, 1'b0);
    run(12, 1'b1, 1'b0, 1'b1, HWG, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, HWG, 1'b1);
    run(2, 1'b1, 1'b0, 1'b1, HWG, 1'b1);
    run(3, 1'b1, 1'b0, 1'b0, HWY, 1'b1);
    run(2, 1'b1, 1'b0, 1'b0, ARA, 1'b1);
    run(2, 1'b1, 1'b0, 1'b0, CRG, 1'b0);

    // Emergency during yellow does not cut it short; clearance returns to highway
    test_name = "emerg_ara";
    do_reset();
    run(7, 1'b1, 1'b0, 1'b0, HWG, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, HWY, 1'b0);
    run(2, 1'b1, 1'b0, 1'b1, HWY, 1'b0);
    run(2, 1'b1, 1'b0, 1'b1, ARA, 1'b0);
    run(4, 1'b1, 1'b0, 1'b1, HWG, 1'b0);

    // Reset for one edge mid-yellow with a pending pedestrian request
    test_name = "reset_mid";
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, 1'b0, HWG, 1'b1);
    run(6, 1'b1, 1'b0, 1'b0, HWG, 1'b1);
    run(2, 1'b1, 1'b0, 1'b0, HWY, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, HWG, 1'b0);
    run(7, 1'b1, 1'b0, 1'b0, HWG, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, HWY, 1'b0);

    // Let the monitor drain the last expectations
    test_name = "drain";
    #1;
    country_car = 1'b0;
    emerg_hw    = 1'b0;
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
